// File: rtl/alu_pkg.sv
// Shared ALU definitions: the subtractor FSM state type and the default datapath width
// used by both the ripple-carry adder and the bit-serial subtractor.
package alu_pkg;
  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {SUB_IDLE, SUB_RUN, SUB_DONE} sub_state_t;
endpackage

// File: rtl/serial_subtractor_fs.sv
// One-bit full-subtractor cell (a - b - bi), the only arithmetic in the serial subtractor.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);
  always_comb begin
    d  = a ^ b ^ bi;
    bo = (~a & b) | (~(a ^ b) & bi);
  end
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor y = A - B - bin, LSB first, start/done handshake.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH + 1);

  sub_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, ysh_q, y_q;
  logic             br_q, bout_q;
  logic             load, step, finish;
  logic             d_bit, bo_bit;

  full_subtractor u_fs (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .bi (br_q),
    .d  (d_bit),
    .bo (bo_bit)
  );

  // WIDTH shifting cycles, then one more RUN cycle publishes the result on the DONE transition
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      SUB_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = SUB_RUN;
        end
      end
      SUB_RUN: begin
        busy = 1'b1;
        if (cnt_q == CW'(WIDTH)) begin
          finish  = 1'b1;
          state_d = SUB_DONE;
        end else begin
          step = 1'b1;
        end
      end
      SUB_DONE: begin
        done = 1'b1;
        if (start) begin
          load    = 1'b1;
          state_d = SUB_RUN;
        end else begin
          state_d = SUB_IDLE;
        end
      end
      default: state_d = SUB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SUB_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      br_q   <= 1'b0;
      ysh_q  <= '0;
      y_q    <= '0;
      bout_q <= 1'b0;
    end else begin
      if (load) begin
        cnt_q <= '0;
        a_q   <= A;
        b_q   <= B;
        br_q  <= bin;
      end else if (step) begin
        cnt_q <= cnt_q + 1'b1;
        a_q   <= a_q >> 1;
        b_q   <= b_q >> 1;
        br_q  <= bo_bit;
        ysh_q <= {d_bit, ysh_q[WIDTH-1:1]};
      end
      // y/bout only move here, so partial differences never reach the outputs
      if (finish) begin
        y_q    <= ysh_q;
        bout_q <= br_q;
      end
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb_q, b_msb_q, ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (load) begin
        a_msb_q <= A[WIDTH-1];
        b_msb_q <= B[WIDTH-1];
      end
      if (finish) ovf_q <= (a_msb_q != b_msb_q) && (ysh_q[WIDTH-1] != a_msb_q);
    end
  end

  assign ovf = ovf_q;
`endif

  assign y    = y_q;
  assign bout = bout_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor (WIDTH=4): directed cases plus random operands against an
// integer-arithmetic reference model.
module tb_serial_subtractor;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] A = '0, B = '0;
  logic         bin = 1'b0;
  logic         busy, done, bout;
  logic [W-1:0] y;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int failures = 0;

  logic [W-1:0] held_y = '0;
  logic         held_bout = 1'b0;
  logic         held_ovf = 1'b0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .y     (y),
    .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer subtraction, range checks for borrow and signed overflow
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                       output logic [W-1:0] ey, output logic eb, output logic eo);
    int d, sa, sb, sd;
    d  = int'(a) - int'(b) - int'(bi);
    ey = W'(d + (1 << W));
    eb = (d < 0);
    sa = (int'(a) >= (1 << (W-1))) ? int'(a) - (1 << W) : int'(a);
    sb = (int'(b) >= (1 << (W-1))) ? int'(b) - (1 << W) : int'(b);
    sd = sa - sb - int'(bi);
    eo = (sd < -(1 << (W-1))) || (sd > (1 << (W-1)) - 1);
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] ey, input logic eb,
                              input logic eo);
    chk({tag, ".y"}, 32'(y), 32'(ey));
    chk({tag, ".bout"}, 32'(bout), 32'(eb));
    chk({tag, ".busy_at_done"}, 32'(busy), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    chk({tag, ".ovf"}, 32'(ovf), 32'(eo));
`endif
    held_y = ey; held_bout = eb; held_ovf = eo;
  endtask

  // Waits for done after an accepted start; expects it WIDTH+1 edges after acceptance
  // and the previous result held on y the whole time.
  task automatic wait_done(input string tag);
    int n;
    logic held_ok;
    n = 0;
    held_ok = 1'b1;
    while (n < 20) begin
      tick();
      n++;
      if (done) break;
      if (y !== held_y || bout !== held_bout) held_ok = 1'b0;
    end
    chk({tag, ".latency"}, 32'(n), 32'(W + 1));
    chk({tag, ".held"}, 32'(held_ok), 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic bi, input bit mid_start);
    logic [W-1:0] ey;
    logic eb, eo;
    int n;
    model(a, b, bi, ey, eb, eo);
    A = a; B = b; bin = bi; start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    if (mid_start) begin
      tick();
      A = ~a; B = a; bin = ~bi; start = 1'b1;
      tick();
      start = 1'b0;
      n = 2;
      while (n < 20 && !done) begin
        tick();
        n++;
      end
      chk({tag, ".latency"}, 32'(n), 32'(W + 1));
    end else begin
      wait_done(tag);
    end
    check_result(tag, ey, eb, eo);
    tick();
    chk({tag, ".done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    logic [W-1:0] ey;
    logic eb, eo;
    int n;
    logic seen_done;

    #12;
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.done", 32'(done), 32'd0);
    chk("reset.y", 32'(y), 32'd0);
    chk("reset.bout", 32'(bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    chk("reset.ovf", 32'(ovf), 32'd0);
`endif
    rst_n = 1'b1;
    tick();

    run_op("t1", 4'b0101, 4'b0011, 1'b0, 1'b0);
    run_op("t2", 4'b0011, 4'b0101, 1'b0, 1'b0);
    run_op("t3", 4'b1000, 4'b0001, 1'b0, 1'b0);
    run_op("t4", 4'b0010, 4'b0101, 1'b1, 1'b1);

    // Back-to-back: second start issued during the DONE cycle of the first
    model(4'b0101, 4'b0011, 1'b0, ey, eb, eo);
    A = 4'b0101; B = 4'b0011; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t5a");
    check_result("t5a", ey, eb, eo);
    model(4'b0111, 4'b0010, 1'b0, ey, eb, eo);
    A = 4'b0111; B = 4'b0010; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5.busy", 32'(busy), 32'd1);
    chk("t5.y_held", 32'(y), 32'(held_y));
    wait_done("t5b");
    check_result("t5b", ey, eb, eo);
    tick();

    // Reset during RUN cycle 2 aborts without a done pulse
    A = 4'b1111; B = 4'b0001; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("t6.busy", 32'(busy), 32'd0);
    chk("t6.y", 32'(y), 32'd0);
    chk("t6.bout", 32'(bout), 32'd0);
    chk("t6.done", 32'(done), 32'd0);
    #3;
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (n = 0; n < 8; n++) begin
      tick();
      if (done) seen_done = 1'b1;
    end
    chk("t6.no_done", 32'(seen_done), 32'd0);
    held_y = '0; held_bout = 1'b0; held_ovf = 1'b0;
    run_op("t6.fresh", 4'b0110, 4'b1001, 1'b1, 1'b0);

    for (int i = 0; i < 30; i++) begin
      run_op("rand", W'($urandom), W'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule
